// File: rtl/monkey_hit_detector_pkg.sv
// Shared types and helpers for the monkey hit detector and its edge classifier.
package monkey_hit_pkg;

  localparam int EDGE_TOP    = 0;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 2;
  localparam int EDGE_LEFT   = 3;

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    ACCUM      = 1'b1
  } hit_state_t;

  // Rope counter increments but holds at its maximum instead of wrapping.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/monkey_hit_detector_if.sv
// Pixel stream in / per-frame collision result out, between the video pipeline and the hit detector.
interface monkey_hit_detector_if;

  logic               startOfFrame;
  logic signed [10:0] pixelX;
  logic signed [10:0] pixelY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               monkeyDR;
  logic               ledgeDR;
  logic               ropeDR;
  logic               enemyDR;
  logic               collision;
  logic               onRope;
  logic               objectHit;
  logic [3:0]         HitEdgeCode;
  logic               resultValid;

  modport master (
    output startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           monkeyDR, ledgeDR, ropeDR, enemyDR,
    input  collision, onRope, objectHit, HitEdgeCode, resultValid
  );

  modport slave (
    input  startOfFrame, pixelX, pixelY, topLeftX, topLeftY,
           monkeyDR, ledgeDR, ropeDR, enemyDR,
    output collision, onRope, objectHit, HitEdgeCode, resultValid
  );

endinterface

// File: rtl/monkey_hit_detector_hit_edge_classifier.sv
// Combinational box test and side classification of a pixel offset inside an object's bounding box.
module hit_edge_classifier
  import monkey_hit_pkg::*;
#(
  parameter int OBJECT_WIDTH  = 64,
  parameter int OBJECT_HEIGHT = 64,
  parameter int EDGE_MARGIN   = 4
) (
  input  logic signed [11:0] offX,
  input  logic signed [11:0] offY,
  output logic               inBox,
  output logic [3:0]         edgeBits
);

  localparam logic signed [11:0] WIDTH_S   = 12'(OBJECT_WIDTH);
  localparam logic signed [11:0] HEIGHT_S  = 12'(OBJECT_HEIGHT);
  localparam logic signed [11:0] MARGIN_S  = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] RIGHT_S   = 12'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic signed [11:0] BOTTOM_S  = 12'(OBJECT_HEIGHT - EDGE_MARGIN);

  // Signed compares so a box hanging off the top/left of the screen never wraps.
  always_comb begin
    inBox    = (offX >= 12'sd0) && (offX < WIDTH_S) &&
               (offY >= 12'sd0) && (offY < HEIGHT_S);
    edgeBits              = 4'b0000;
    edgeBits[EDGE_TOP]    = (offY < MARGIN_S);
    edgeBits[EDGE_RIGHT]  = (offX >= RIGHT_S);
    edgeBits[EDGE_BOTTOM] = (offY >= BOTTOM_S);
    edgeBits[EDGE_LEFT]   = (offX < MARGIN_S);
  end

endmodule

// File: rtl/monkey_hit_detector.sv
// Accumulates monkey/ledge/rope/enemy overlaps over a video frame and publishes
// the completed frame's result on startOfFrame, held stable for the next frame.
module monkey_hit_detector
  import monkey_hit_pkg::*;
#(
  parameter int OBJECT_WIDTH    = 64,
  parameter int OBJECT_HEIGHT   = 64,
  parameter int EDGE_MARGIN     = 4,
  parameter int ROPE_MIN_PIXELS = 8
) (
  input logic                  clk,
  input logic                  reset,
  monkey_hit_detector_if.slave bus
);

  localparam logic [7:0] ROPE_MIN = 8'(ROPE_MIN_PIXELS);

  hit_state_t         state;
  logic signed [11:0] offX;
  logic signed [11:0] offY;
  logic               inBox;
  logic [3:0]         edgeBits;
  logic               qualified;

  logic               accCollision;
  logic               accHit;
  logic [3:0]         accEdge;
  logic [7:0]         ropeCnt;

  logic               nextCollision;
  logic               nextHit;
  logic [3:0]         nextEdge;
  logic [7:0]         nextRope;

  assign offX = $signed({bus.pixelX[10], bus.pixelX}) - $signed({bus.topLeftX[10], bus.topLeftX});
  assign offY = $signed({bus.pixelY[10], bus.pixelY}) - $signed({bus.topLeftY[10], bus.topLeftY});

  hit_edge_classifier #(
    .OBJECT_WIDTH (OBJECT_WIDTH),
    .OBJECT_HEIGHT(OBJECT_HEIGHT),
    .EDGE_MARGIN  (EDGE_MARGIN)
  ) u_classifier (
    .offX    (offX),
    .offY    (offY),
    .inBox   (inBox),
    .edgeBits(edgeBits)
  );

  assign qualified = bus.monkeyDR & inBox;

  // A pixel coincident with startOfFrame lands in the freshly cleared accumulators.
  always_comb begin
    logic       baseCollision;
    logic       baseHit;
    logic [3:0] baseEdge;
    logic [7:0] baseRope;
    if (bus.startOfFrame) begin
      baseCollision = 1'b0;
      baseHit       = 1'b0;
      baseEdge      = 4'b0000;
      baseRope      = 8'd0;
    end else begin
      baseCollision = accCollision;
      baseHit       = accHit;
      baseEdge      = accEdge;
      baseRope      = ropeCnt;
    end
    nextCollision = baseCollision | (qualified & bus.ledgeDR);
    nextHit       = baseHit | (qualified & bus.enemyDR);
    nextEdge      = (qualified & bus.ledgeDR) ? (baseEdge | edgeBits) : baseEdge;
    nextRope      = (qualified & bus.ropeDR) ? satInc8(baseRope) : baseRope;
  end

  // Frame FSM: accumulators, publication of the finished frame and result pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT_FIRST;
      accCollision    <= 1'b0;
      accHit          <= 1'b0;
      accEdge         <= 4'b0000;
      ropeCnt         <= 8'd0;
      bus.collision   <= 1'b0;
      bus.onRope      <= 1'b0;
      bus.objectHit   <= 1'b0;
      bus.HitEdgeCode <= 4'b0000;
      bus.resultValid <= 1'b0;
    end else begin
      accCollision <= nextCollision;
      accHit       <= nextHit;
      accEdge      <= nextEdge;
      ropeCnt      <= nextRope;
      case (state)
        WAIT_FIRST: begin
          bus.resultValid <= 1'b0;
          if (bus.startOfFrame) begin
            state <= ACCUM;
          end else begin
            state <= WAIT_FIRST;
          end
        end
        ACCUM: begin
          state <= ACCUM;
          if (bus.startOfFrame) begin
            bus.collision   <= accCollision;
            bus.objectHit   <= accHit;
            bus.onRope      <= (ropeCnt >= ROPE_MIN);
            bus.HitEdgeCode <= accCollision ? accEdge : 4'b0000;
            bus.resultValid <= 1'b1;
          end else begin
            bus.resultValid <= 1'b0;
          end
        end
        default: begin
          state           <= WAIT_FIRST;
          bus.resultValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_monkey_hit_detector.sv
// Directed-vector bench for monkey_hit_detector with hand-computed frame results.
module tb_monkey_hit_detector;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  monkey_hit_detector_if bus ();

  monkey_hit_detector dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.startOfFrame = 1'b0;
    bus.monkeyDR     = 1'b0;
    bus.ledgeDR      = 1'b0;
    bus.ropeDR       = 1'b0;
    bus.enemyDR      = 1'b0;
  endtask

  task automatic setMonkey(input int x, input int y);
    bus.topLeftX = 11'(x);
    bus.topLeftY = 11'(y);
  endtask

  // One pixel cycle; sof=1 makes it coincide with startOfFrame.
  task automatic pixel(input int x, input int y, input logic m, input logic l,
                       input logic r, input logic e, input logic sof);
    bus.pixelX       = 11'(x);
    bus.pixelY       = 11'(y);
    bus.monkeyDR     = m;
    bus.ledgeDR      = l;
    bus.ropeDR       = r;
    bus.enemyDR      = e;
    bus.startOfFrame = sof;
    tick();
    idle();
  endtask

  task automatic frameEnd();
    bus.startOfFrame = 1'b1;
    tick();
    idle();
  endtask

  task automatic checkOut(input string tag, input logic rv, input logic col,
                          input logic rope, input logic hit, input logic [3:0] edgeCode);
    checkVal({tag, ".resultValid"}, 32'(bus.resultValid), 32'(rv));
    checkVal({tag, ".collision"},   32'(bus.collision),   32'(col));
    checkVal({tag, ".onRope"},      32'(bus.onRope),      32'(rope));
    checkVal({tag, ".objectHit"},   32'(bus.objectHit),   32'(hit));
    checkVal({tag, ".edge"},        32'(bus.HitEdgeCode), 32'(edgeCode));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    idle();
    bus.pixelX = 11'sd0;
    bus.pixelY = 11'sd0;
    setMonkey(280, 185);
    reset = 1'b1;
    tick();
    tick();
    checkOut("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    reset = 1'b0;

    // Partial frame after reset is discarded.
    pixel(290, 247, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frameEnd();
    checkOut("discard", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Bottom-edge ledge hit (offY=63); offY=64 lies outside the box.
    pixel(300, 248, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pixel(300, 249, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    pixel(300, 220, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    frameEnd();
    checkOut("bottom", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100);
    pixel(300, 249, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOut("bottomHold", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100);

    // Rope threshold: 7, 8, 300, 256 pixels.
    for (int i = 0; i < 7; i++) pixel(310, 215, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frameEnd();
    checkOut("rope7", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 8; i++) pixel(310, 215, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frameEnd();
    checkOut("rope8", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 300; i++) pixel(310, 215, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frameEnd();
    checkOut("rope300", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 256; i++) pixel(310, 215, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    frameEnd();
    checkOut("rope256", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000);

    // Enemy at (0,0) plus ledge at (63,0): top-right corner.
    pixel(280, 185, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pixel(343, 185, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frameEnd();
    checkOut("corner", 1'b1, 1'b1, 1'b0, 1'b1, 4'b0011);

    // Ledge overlap coincident with startOfFrame belongs to the next frame.
    pixel(300, 205, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOut("coincident", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    tick();
    frameEnd();
    checkOut("coincidentNext", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    frameEnd();
    checkOut("backToBack", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Monkey partially off the left of the screen.
    setMonkey(-9, 100);
    pixel(-10, 110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frameEnd();
    checkOut("offLeftIgnored", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    pixel(0, 110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    frameEnd();
    checkOut("offLeftCounted", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);

    // Mid-frame reset clears outputs and returns to WAIT_FIRST.
    pixel(0, 110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOut("midReset", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    pixel(0, 110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    frameEnd();
    checkOut("afterReset", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/monkey_hit_detector.md
Name: monkey_hit_detector

Overview:
- Per-pixel collision accumulator feeding the monkey movement/collision block. It produces that block's collision, onRope, objectHit and HitEdgeCode inputs.
- During each video frame it watches the per-pixel drawing requests of the monkey, ledges, ropes and enemies, and accumulates overlap facts in sticky registers.
- On startOfFrame it publishes the completed frame's result, which is held stable for the whole next frame, then clears the accumulators.

Parameters:
- OBJECT_WIDTH, 64: monkey bounding-box width in pixels.
- OBJECT_HEIGHT, 64: monkey bounding-box height in pixels.
- EDGE_MARGIN, 4: a pixel within this many pixels of a box side counts as touching that side.
- ROPE_MIN_PIXELS, 8: minimum monkey∩rope pixel count per frame to assert onRope.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse at frame start
- pixelX  in  11  current pixel column, signed
- pixelY  in  11  current pixel row, signed
- topLeftX  in  11  monkey box left, signed
- topLeftY  in  11  monkey box top, signed
- monkeyDR  in  1  monkey drawing request for the current pixel
- ledgeDR  in  1  ledge/platform drawing request
- ropeDR  in  1  rope drawing request
- enemyDR  in  1  enemy/fruit drawing request
- collision  out  1  monkey overlapped a ledge last frame
- onRope  out  1  rope overlap count ≥ ROPE_MIN_PIXELS last frame
- objectHit  out  1  monkey overlapped an enemy last frame
- HitEdgeCode  out  4  sides touched by ledge overlap last frame: [0] top, [1] right, [2] bottom, [3] left
- resultValid  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (sync, high): all outputs 0; accumulators cleared; state goes to WAIT_FIRST.
- Offset: offX = pixelX − topLeftX and offY = pixelY − topLeftY, computed in 12-bit signed. Overlap events are qualified only when monkeyDR=1 and 0 ≤ off < size.
- Edge classification (combinational):
  - top if offY < EDGE_MARGIN.
  - bottom if offY ≥ OBJECT_HEIGHT − EDGE_MARGIN.
  - left if offX < EDGE_MARGIN.
  - right if offX ≥ OBJECT_WIDTH − EDGE_MARGIN.
  - Several bits may be set at once (corners).
- Accumulation on each qualified cycle:
  - ledgeDR: set accCollision; OR the edge bits into accEdge.
  - enemyDR: set accHit.
  - ropeDR: increment ropeCnt (8-bit, saturating at 255).
  - A pixel with several DRs set updates all matching accumulators.
- FSM states and transitions:
  - WAIT_FIRST: accumulate, publish nothing. On the first startOfFrame, clear accumulators and go to ACCUM. This discards the partial frame after reset.
  - ACCUM: accumulate.
    - On startOfFrame, on the next clock edge:
      - collision ← accCollision.
      - objectHit ← accHit & ~accCollision-independent (objectHit is not masked).
      - onRope ← (ropeCnt ≥ ROPE_MIN_PIXELS).
      - HitEdgeCode ← accEdge if accCollision, else 0.
      - resultValid ← 1 for one cycle; accumulators cleared.
    - Remain in ACCUM.
- Latency: the result reflects frame N and is visible from the cycle after the startOfFrame that ends frame N. It is constant until the next startOfFrame.
- Simultaneous startOfFrame and a qualified overlap: that pixel belongs to the new frame. It is loaded into the freshly cleared accumulators, not the published result.
- Boundary handling:
  - A partially off-screen monkey (negative topLeft) uses the signed compare; no wrap.
  - Back-to-back startOfFrame on consecutive cycles: the second publishes an empty frame (all zeros).
  - reset mid-frame: outputs go to 0 and the FSM returns to WAIT_FIRST.
- Consumer invariant: HitEdgeCode ≠ 0 implies collision = 1.

Decomposition:
- Package monkey_hit_pkg holds:
  - localparam edge indices EDGE_TOP=0, EDGE_RIGHT=1, EDGE_BOTTOM=2, EDGE_LEFT=3;
  - typedef enum logic [0:0] {WAIT_FIRST, ACCUM} hit_state_t.
- Sub-module hit_edge_classifier is combinational: offsets in; inBox and the 4-bit edge vector out. It is reused later by enemy blocks.

Test Plan:
- reset, then a ledge overlap at offset (10,62) before the first startOfFrame. At the first startOfFrame, resultValid stays 0 and outputs stay 0, because the partial frame is discarded.
- Monkey at (280,185); ledge overlap at pixel (300,248) (offY=63). The next startOfFrame publishes collision=1, HitEdgeCode=4'b0100, held for the full frame.
- 7 rope-overlap pixels in a frame → onRope=0. 8 pixels in the following frame → onRope=1 after that frame's closing startOfFrame. 300 pixels → counter saturates and onRope=1.
- Enemy overlap at offset (0,0) plus a ledge overlap at offset (63,0) in the same frame → objectHit=1, collision=1, HitEdgeCode=4'b0011.
- Ledge overlap coincident with the startOfFrame cycle → published collision=0; the frame after shows collision=1.
- topLeftX=−9 with a pixel at pixelX=0 (offX=9) → counted, no edge bit. Pixel at pixelX=−10 → ignored. reset asserted mid-frame → all outputs 0 on the next cycle.
